// File: rtl/clk_edge_counter_pkg.sv
// Shared types and constants for the clock edge counter.
package clk_edge_counter_pkg;

  localparam int unsigned MIN_SYNC_STAGES = 2;
  localparam int unsigned WINDOW_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/clk_mon_sync.sv
// Synchronizer chain plus rising-edge detector for one asynchronous clock input.
module clk_mon_sync
  import clk_edge_counter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise_c
);

  // Never build fewer stages than the metastability floor.
  localparam int unsigned STAGES =
    (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/clk_edge_counter.sv
// Counts rising edges of a selected monitored clock over a window of core cycles.
// Optional interrupt output enabled by defining CLK_EDGE_COUNTER_IRQ_EN.
module clk_edge_counter
  import clk_edge_counter_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mon_user_clk,
  input  logic                mon_core_clk,
  input  logic                sel,
  input  logic                start,
  input  logic                abort,
  input  logic [WINDOW_W-1:0] window,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    count,
  output logic                overflow
`ifdef CLK_EDGE_COUNTER_IRQ_EN
  ,
  input  logic                irq_clear,
  output logic                irq
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state;
  state_t              state_nxt;
  logic                sel_q;
  logic [WINDOW_W-1:0] window_q;
  logic [WINDOW_W-1:0] rem_q;
  logic                rise_user;
  logic                rise_core;
  logic                edge_sel;
  logic                accept;
  logic                busy_nxt;
  logic                done_nxt;

  clk_mon_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_user (
    .clock  (clock),
    .reset  (reset),
    .din    (mon_user_clk),
    .rise_c (rise_user)
  );

  clk_mon_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_core (
    .clock  (clock),
    .reset  (reset),
    .din    (mon_core_clk),
    .rise_c (rise_core)
  );

  assign edge_sel = sel_q ? rise_core : rise_user;
  // abort beats a simultaneous start
  assign accept   = ((state == ST_IDLE) || (state == ST_DONE)) && start && !abort;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (abort)                         state_nxt = ST_IDLE;
        else if (window_q == '0)           state_nxt = ST_DONE;
        else                               state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (abort)                         state_nxt = ST_IDLE;
        else if (rem_q <= WINDOW_W'(1))    state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status flags are decoded from the next state so the registered outputs track state.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state_nxt)
      ST_ARM, ST_COUNT: busy_nxt = 1'b1;
      ST_DONE:          done_nxt = 1'b1;
      default:          ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      sel_q    <= 1'b0;
      window_q <= '0;
      rem_q    <= '0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (accept) begin
        sel_q    <= sel;
        window_q <= window;
        count    <= '0;
        overflow <= 1'b0;
      end
      if (state == ST_ARM) begin
        rem_q <= window_q;
      end
      // An aborted cycle contributes no edge.
      if ((state == ST_COUNT) && !abort) begin
        rem_q <= rem_q - WINDOW_W'(1);
        if (edge_sel) begin
          if (count == CNT_MAX) overflow <= 1'b1;
          else                  count    <= count + CNT_W'(1);
        end
      end
    end
  end

`ifdef CLK_EDGE_COUNTER_IRQ_EN
  // A DONE entry outranks a same-cycle clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq <= 1'b0;
    end else if ((state_nxt == ST_DONE) && (state != ST_DONE)) begin
      irq <= 1'b1;
    end else if (irq_clear) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_clk_edge_counter.sv
// Scoreboard bench for clk_edge_counter: a 16-bit and an 8-bit instance share stimulus.
module tb_clk_edge_counter;

  logic        clock = 1'b0;
  logic        reset;
  logic        mon_user_clk;
  logic        mon_core_clk;
  logic        sel;
  logic        start;
  logic        abort;
  logic [15:0] window;
  logic        busy, done, overflow;
  logic [15:0] count;
  logic        busy8, done8, overflow8;
  logic [7:0]  count8;
`ifdef CLK_EDGE_COUNTER_IRQ_EN
  logic        irq_clear;
  logic        irq, irq8;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned cnt;
    logic        ovf;
    int unsigned cnt8;
    logic        ovf8;
  } exp_t;

  exp_t sb[$];

  logic user_en = 1'b0;
  logic core_en = 1'b0;
  int   user_half = 2;
  int   core_half = 2;
  int   ucnt = 0;
  int   ccnt = 0;

  always #5 clock = ~clock;

  clk_edge_counter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .mon_user_clk(mon_user_clk), .mon_core_clk(mon_core_clk),
    .sel(sel), .start(start), .abort(abort), .window(window),
    .busy(busy), .done(done), .count(count), .overflow(overflow)
`ifdef CLK_EDGE_COUNTER_IRQ_EN
    , .irq_clear(irq_clear), .irq(irq)
`endif
  );

  clk_edge_counter #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
    .clock(clock), .reset(reset), .mon_user_clk(mon_user_clk), .mon_core_clk(mon_core_clk),
    .sel(sel), .start(start), .abort(abort), .window(window),
    .busy(busy8), .done(done8), .count(count8), .overflow(overflow8)
`ifdef CLK_EDGE_COUNTER_IRQ_EN
    , .irq_clear(irq_clear), .irq(irq8)
`endif
  );

  // Monitored clock generators, stepped on the falling edge of the core clock
  initial begin
    mon_user_clk = 1'b0;
    forever begin
      @(negedge clock);
      if (!user_en) begin
        mon_user_clk = 1'b0;
        ucnt = 0;
      end else begin
        ucnt++;
        if (ucnt >= user_half) begin
          ucnt = 0;
          mon_user_clk = ~mon_user_clk;
        end
      end
    end
  end

  initial begin
    mon_core_clk = 1'b0;
    forever begin
      @(negedge clock);
      if (!core_en) begin
        mon_core_clk = 1'b0;
        ccnt = 0;
      end else begin
        ccnt++;
        if (ccnt >= core_half) begin
          ccnt = 0;
          mon_core_clk = ~mon_core_clk;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic exp_t mk_exp(int unsigned c, logic o, int unsigned c8, logic o8);
    exp_t e;
    e.cnt = c; e.ovf = o; e.cnt8 = c8; e.ovf8 = o8;
    return e;
  endfunction

  task automatic issue_start(input logic s, input logic [15:0] w, input exp_t e);
    sel = s;
    window = w;
    start = 1'b1;
    sb.push_back(e);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output logic to);
    n = 0;
    to = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      tick();
      n++;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; abort = 1'b0; sel = 1'b0; window = 16'd5;
    tick();
    tick();
    reset = 1'b0; start = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
    total++; if (count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
`ifdef CLK_EDGE_COUNTER_IRQ_EN
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %0b want 0", irq); end
`endif
  endtask

  task automatic test_user_clock();
    int   n;
    logic to;
    exp_t e;
    user_en = 1'b1; user_half = 2; core_en = 1'b0;
    repeat (10) tick();
    issue_start(1'b0, 16'd516, mk_exp(129, 1'b0, 129, 1'b0));
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL user_busy_arm: got %0b want 1", busy); end
    wait_done(n, to);
    e = sb.pop_front();
    total++; if (to !== 1'b0) begin bad++; $display("FAIL user_timeout: got %0b want 0", to); end
    total++; if (n != 517) begin bad++; $display("FAIL user_latency: got %0d want 517", n); end
    total++; if (count !== 16'(e.cnt)) begin bad++; $display("FAIL user_count: got %0d want %0d", count, e.cnt); end
    total++; if (overflow !== e.ovf) begin bad++; $display("FAIL user_overflow: got %0b want %0b", overflow, e.ovf); end
    total++; if (count8 !== 8'(e.cnt8)) begin bad++; $display("FAIL user_count8: got %0d want %0d", count8, e.cnt8); end
    repeat (10) tick();
    total++; if (done !== 1'b1 || count !== 16'(e.cnt)) begin
      bad++; $display("FAIL done_hold: got done=%0b count=%0d want done=1 count=%0d", done, count, e.cnt);
    end
  endtask

  task automatic test_sel();
    int   n;
    logic to;
    exp_t e;
    user_en = 1'b1; user_half = 3; core_en = 1'b1; core_half = 2;
    repeat (10) tick();
    issue_start(1'b1, 16'd516, mk_exp(129, 1'b0, 129, 1'b0));
    wait_done(n, to);
    e = sb.pop_front();
    total++; if (to !== 1'b0 || count !== 16'(e.cnt)) begin
      bad++; $display("FAIL sel_core_count: got %0d (timeout=%0b) want %0d", count, to, e.cnt);
    end
    issue_start(1'b0, 16'd516, mk_exp(86, 1'b0, 86, 1'b0));
    wait_done(n, to);
    e = sb.pop_front();
    total++; if (to !== 1'b0 || count !== 16'(e.cnt)) begin
      bad++; $display("FAIL sel_user_count: got %0d (timeout=%0b) want %0d", count, to, e.cnt);
    end
    total++; if (count8 !== 8'(e.cnt8)) begin bad++; $display("FAIL sel_user_count8: got %0d want %0d", count8, e.cnt8); end
  endtask

  task automatic test_overflow();
    int   n;
    logic to;
    exp_t e;
    user_en = 1'b1; user_half = 2; core_en = 1'b0;
    repeat (10) tick();
    issue_start(1'b0, 16'd2000, mk_exp(500, 1'b0, 255, 1'b1));
    wait_done(n, to);
    e = sb.pop_front();
    total++; if (to !== 1'b0) begin bad++; $display("FAIL ovf_timeout: got %0b want 0", to); end
    total++; if (count8 !== 8'(e.cnt8)) begin bad++; $display("FAIL ovf_count8: got %0d want %0d", count8, e.cnt8); end
    total++; if (overflow8 !== e.ovf8) begin bad++; $display("FAIL ovf_flag8: got %0b want %0b", overflow8, e.ovf8); end
    total++; if (count !== 16'(e.cnt) || overflow !== e.ovf) begin
      bad++; $display("FAIL ovf_wide: got %0d/%0b want %0d/%0b", count, overflow, e.cnt, e.ovf);
    end
    issue_start(1'b0, 16'd8, mk_exp(2, 1'b0, 2, 1'b0));
    total++; if (count8 !== 8'd0 || overflow8 !== 1'b0 || done8 !== 1'b0) begin
      bad++; $display("FAIL ovf_clear: got count=%0d ovf=%0b done=%0b want 0/0/0", count8, overflow8, done8);
    end
    wait_done(n, to);
    e = sb.pop_front();
    total++; if (to !== 1'b0 || count8 !== 8'(e.cnt8) || overflow8 !== e.ovf8) begin
      bad++; $display("FAIL ovf_recount: got %0d/%0b want %0d/%0b", count8, overflow8, e.cnt8, e.ovf8);
    end
  endtask

  task automatic test_window_zero();
    exp_t e;
    issue_start(1'b0, 16'd0, mk_exp(0, 1'b0, 0, 1'b0));
    total++; if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL wz_arm: got busy=%0b done=%0b want 1/0", busy, done);
    end
    tick();
    e = sb.pop_front();
    total++; if (busy !== 1'b0 || done !== 1'b1 || count !== 16'(e.cnt)) begin
      bad++; $display("FAIL wz_done: got busy=%0b done=%0b count=%0d want 0/1/%0d", busy, done, count, e.cnt);
    end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b1) begin
      bad++; $display("FAIL wz_abort_blocks_done: got busy=%0b done=%0b want 0/1", busy, done);
    end
    sel = 1'b0; window = 16'd100; start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL arm_abort: got busy=%0b done=%0b want 0/0", busy, done);
    end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL idle_abort_blocks: got busy=%0b done=%0b want 0/0", busy, done);
    end
  endtask

  task automatic test_abort();
    user_en = 1'b1; user_half = 2; core_en = 1'b0;
    repeat (10) tick();
    sel = 1'b0; window = 16'd1000; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (98) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_state: got busy=%0b done=%0b want 0/0", busy, done);
    end
    total++; if (count < 16'd24 || count > 16'd26) begin
      bad++; $display("FAIL abort_partial: got %0d want 24..26", count);
    end
    repeat (8) tick();
    total++; if (done !== 1'b0 || count < 16'd24 || count > 16'd26) begin
      bad++; $display("FAIL abort_hold: got done=%0b count=%0d want 0 and 24..26", done, count);
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0; window = 16'd1000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (60) tick();
    total++; if (busy !== 1'b1 || count < 16'd13 || count > 16'd16) begin
      bad++; $display("FAIL mid_progress: got busy=%0b count=%0d want 1 and 13..16", busy, count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || count !== 16'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got busy=%0b done=%0b count=%0d ovf=%0b want all 0", busy, done, count, overflow);
    end
    repeat (5) tick();
    total++; if (busy !== 1'b0 || count !== 16'd0) begin
      bad++; $display("FAIL mid_reset_stay: got busy=%0b count=%0d want 0/0", busy, count);
    end
  endtask

`ifdef CLK_EDGE_COUNTER_IRQ_EN
  task automatic test_irq();
    int   n;
    logic to;
    exp_t e;
    user_en = 1'b1; user_half = 2; core_en = 1'b0;
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: got %0b want 0", irq); end
    issue_start(1'b0, 16'd4, mk_exp(1, 1'b0, 1, 1'b0));
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_busy: got %0b want 0", irq); end
    wait_done(n, to);
    e = sb.pop_front();
    total++; if (to !== 1'b0 || irq !== 1'b1) begin bad++; $display("FAIL irq_rise: got %0b want 1", irq); end
    total++; if (count !== 16'(e.cnt)) begin bad++; $display("FAIL irq_count: got %0d want %0d", count, e.cnt); end
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear2: got %0b want 0", irq); end
    issue_start(1'b0, 16'd0, mk_exp(0, 1'b0, 0, 1'b0));
    irq_clear = 1'b1;
    tick();
    irq_clear = 1'b0;
    e = sb.pop_front();
    total++; if (irq !== 1'b1 || done !== 1'b1 || count !== 16'(e.cnt)) begin
      bad++; $display("FAIL irq_set_wins: got irq=%0b done=%0b count=%0d want 1/1/%0d", irq, done, count, e.cnt);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; sel = 1'b0; window = 16'd0;
`ifdef CLK_EDGE_COUNTER_IRQ_EN
    irq_clear = 1'b0;
`endif
    test_reset();
    test_user_clock();
    test_sel();
    test_overflow();
    test_window_zero();
    test_abort();
    test_reset_mid();
`ifdef CLK_EDGE_COUNTER_IRQ_EN
    test_irq();
`endif
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left: got %0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
